pwm_ramp_ctrl: RTL and testbench

- Soft-start/slew controller placed in front of the pwm generator; drives its 8-bit duty input.
- Accepts a target duty over a valid/ready handshake.
- Walks duty toward the target by STEP every STEP_PERIODS PWM periods, so duty changes never make abrupt jumps.
- Keeps a free-running period timer with the same CLK_FREQ/PWM_FREQ derivation as the pwm, so updates align to period boundaries.

---
 rtl/pwm_ctrl_pkg.sv | 21 ++
 rtl/pwm_period_timer.sv | 40 ++++
 rtl/pwm_ramp_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ctrl_pkg
// Brief    : Shared types and helpers for the PWM ramp controller and timer.
// Revision : 1.0
// ============================================================================
package pwm_ctrl_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  function automatic int period_cnt_w(input int period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_period_timer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_period_timer
// Brief    : Free-running PWM period counter; pulses on the last clock of each period.
// Revision : 1.0
// ============================================================================
module pwm_period_timer
  import pwm_ctrl_pkg::*;
#(
  parameter int CLK_FREQ = 1_000_000,
  parameter int PWM_FREQ = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic period_tick
);

  localparam int PERIOD = CLK_FREQ / PWM_FREQ;
  localparam int CNT_W  = period_cnt_w(PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign period_tick = (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_ctrl
// Brief    : Slews the PWM duty toward a requested target in STEP increments,
//            paced by STEP_PERIODS PWM periods. Optional fault latch: PWM_RAMP_FAULT_EN.
// Revision : 1.0
// ============================================================================
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int CLK_FREQ     = 1_000_000,
  parameter int PWM_FREQ     = 1000,
  parameter int STEP         = 1,
  parameter int STEP_PERIODS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] tgt_duty,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done,
  output logic              period_tick
`ifdef PWM_RAMP_FAULT_EN
  ,
  input  logic              fault,
  input  logic              fault_clr
`endif
);

  localparam int SC_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [SC_W-1:0]   SC_LAST = SC_W'(STEP_PERIODS - 1);
  localparam logic [DUTY_W:0]   STEP_W9 = (DUTY_W + 1)'(STEP);
  localparam logic [DUTY_W-1:0] STEP_W8 = DUTY_W'(STEP);

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [SC_W-1:0]   step_cnt_q, step_cnt_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              accept;
  logic              step_tick;
  logic [DUTY_W:0]   diff;

  pwm_period_timer #(
    .CLK_FREQ (CLK_FREQ),
    .PWM_FREQ (PWM_FREQ)
  ) u_period_timer (
    .clk         (clk),
    .rst         (rst),
    .period_tick (period_tick)
  );

`ifdef PWM_RAMP_FAULT_EN
  logic fault_latched_q, fault_latched_d;
  assign tgt_ready = (state_q == IDLE) && !fault_latched_q;
`else
  assign tgt_ready = (state_q == IDLE);
`endif

  assign accept    = tgt_valid && tgt_ready;
  assign step_tick = period_tick && (state_q == RAMP) && (step_cnt_q == SC_LAST);

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    target_d   = target_q;
    step_cnt_d = step_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    // Nine-bit distance so a STEP of up to 255 compares without overflow.
    diff = (target_q >= duty_q) ? ({1'b0, target_q} - {1'b0, duty_q})
                                : ({1'b0, duty_q} - {1'b0, target_q});

    case (state_q)
      IDLE: begin
        if (accept) begin
          target_d   = tgt_duty;
          step_cnt_d = '0;
          if (tgt_duty == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
            busy_d  = 1'b1;
          end
        end
      end
      RAMP: begin
        if (period_tick) begin
          step_cnt_d = step_tick ? '0 : step_cnt_q + SC_W'(1);
        end
        if (step_tick) begin
          if (diff <= STEP_W9) begin
            duty_d  = target_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else if (target_q > duty_q) begin
            duty_d = duty_q + STEP_W8;
          end else begin
            duty_d = duty_q - STEP_W8;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef PWM_RAMP_FAULT_EN
    // A fault overrides everything decided above in the same cycle.
    fault_latched_d = fault_latched_q;
    if (fault) begin
      state_d         = IDLE;
      duty_d          = '0;
      busy_d          = 1'b0;
      done_d          = 1'b0;
      fault_latched_d = 1'b1;
    end else if (fault_clr) begin
      fault_latched_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      target_q   <= '0;
      step_cnt_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      step_cnt_q <= step_cnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

`ifdef PWM_RAMP_FAULT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_latched_q <= 1'b0;
    end else begin
      fault_latched_q <= fault_latched_d;
    end
  end
`endif

  assign duty = duty_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_ramp_ctrl
// Brief    : Directed, table-driven bench for pwm_ramp_ctrl (PERIOD=10).
// Revision : 1.0
// ============================================================================
module tb_pwm_ramp_ctrl;

  typedef struct packed {
    logic           sel;   // 0: STEP=16/STEP_PERIODS=1, 1: STEP=100/STEP_PERIODS=3
    logic [7:0]     tgt;
    logic [2:0]     n;     // expected number of duty changes (0 = equal target)
    logic [4:0][7:0] exp;  // exp[k] = duty after change k (or held duty when n==0)
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tgt_duty = 8'd0;
  logic       tgt_valid_a = 1'b0;
  logic       tgt_valid_b = 1'b0;
  logic       tgt_ready_a, tgt_ready_b;
  logic [7:0] duty_a, duty_b;
  logic       busy_a, busy_b, done_a, done_b, tick_a, tick_b;
  logic       sel = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  vec_t vecs [0:9];
  int   nvec;

  always #5 clk = ~clk;

`ifdef PWM_RAMP_FAULT_EN
  logic fault = 1'b0;
  logic fault_clr = 1'b0;
`endif

  pwm_ramp_ctrl #(
    .CLK_FREQ(100), .PWM_FREQ(10), .STEP(16), .STEP_PERIODS(1)
  ) dut_a (
    .clk(clk), .rst(rst), .tgt_duty(tgt_duty), .tgt_valid(tgt_valid_a),
    .tgt_ready(tgt_ready_a), .duty(duty_a), .busy(busy_a), .done(done_a),
    .period_tick(tick_a)
`ifdef PWM_RAMP_FAULT_EN
    , .fault(fault), .fault_clr(fault_clr)
`endif
  );

  pwm_ramp_ctrl #(
    .CLK_FREQ(100), .PWM_FREQ(10), .STEP(100), .STEP_PERIODS(3)
  ) dut_b (
    .clk(clk), .rst(rst), .tgt_duty(tgt_duty), .tgt_valid(tgt_valid_b),
    .tgt_ready(tgt_ready_b), .duty(duty_b), .busy(busy_b), .done(done_b),
    .period_tick(tick_b)
`ifdef PWM_RAMP_FAULT_EN
    , .fault(1'b0), .fault_clr(1'b0)
`endif
  );

  logic [7:0] duty_s;
  logic       busy_s, done_s, tgt_ready_s, tick_s;
  assign duty_s      = sel ? duty_b      : duty_a;
  assign busy_s      = sel ? busy_b      : busy_a;
  assign done_s      = sel ? done_b      : done_a;
  assign tgt_ready_s = sel ? tgt_ready_b : tgt_ready_a;
  assign tick_s      = sel ? tick_b      : tick_a;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [7:0] t, input logic [2:0] n,
                              input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3, input logic [7:0] e4);
    vec_t v;
    v.sel = s;
    v.tgt = t;
    v.n   = n;
    v.exp = {e4, e3, e2, e1, e0};
    return v;
  endfunction

  // Waits for duty to move, counting period ticks and checking ramp-time flags.
  task automatic wait_change(input logic [7:0] prev, input int limit, output int ticks,
                             output int cycles, output bit changed, output bit bad);
    ticks = 0; cycles = 0; changed = 1'b0; bad = 1'b0;
    while (!changed && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (duty_s !== prev) begin
        changed = 1'b1;
      end else begin
        if (tick_s) ticks++;
        if (busy_s !== 1'b1 || tgt_ready_s !== 1'b0 || done_s !== 1'b0) bad = 1'b1;
      end
    end
  endtask

  task automatic apply_vec(input vec_t v);
    logic [7:0] prev;
    int ticks, cycles, sp;
    bit changed, bad;
    sel = v.sel;
    sp  = v.sel ? 3 : 1;
    @(negedge clk);
    prev     = duty_s;
    tgt_duty = v.tgt;
    if (v.sel) tgt_valid_b = 1'b1; else tgt_valid_a = 1'b1;
    @(posedge clk);
    #1;
    tgt_valid_a = 1'b0;
    tgt_valid_b = 1'b0;
    if (v.n == 3'd0) begin
      @(negedge clk);
      chk("eq_done", 32'(done_s), 32'd1);
      chk("eq_busy", 32'(busy_s), 32'd0);
      chk("eq_duty", 32'(duty_s), 32'(v.exp[0]));
      @(negedge clk);
      chk("eq_done_pulse", 32'(done_s), 32'd0);
    end else begin
      for (int k = 0; k < int'(v.n); k++) begin
        wait_change(prev, 10 * sp + 5, ticks, cycles, changed, bad);
        chk("step_seen", 32'(changed), 32'd1);
        chk("step_duty", 32'(duty_s), 32'(v.exp[k]));
        chk("step_ticks", 32'(ticks), 32'(sp));
        chk("ramp_flags", 32'(bad), 32'd0);
        if (k > 0) chk("step_spacing", 32'(cycles), 32'(10 * sp));
        if (k == int'(v.n) - 1) begin
          chk("final_done", 32'(done_s), 32'd1);
          chk("final_busy", 32'(busy_s), 32'd0);
          chk("final_ready", 32'(tgt_ready_s), 32'd1);
          @(negedge clk);
          chk("done_pulse", 32'(done_s), 32'd0);
        end else begin
          chk("mid_done", 32'(done_s), 32'd0);
        end
        prev = duty_s;
      end
    end
  endtask

  initial begin
    int ticks, cycles, first;
    bit changed, bad;

    vecs[0] = mk(1'b0, 8'd64, 3'd4, 8'd16, 8'd32, 8'd48, 8'd64, 8'd0);
    vecs[1] = mk(1'b0, 8'd10, 3'd4, 8'd48, 8'd32, 8'd16, 8'd10, 8'd0);
    vecs[2] = mk(1'b0, 8'd0,  3'd1, 8'd0,  8'd0,  8'd0,  8'd0,  8'd0);
    vecs[3] = mk(1'b0, 8'd0,  3'd0, 8'd0,  8'd0,  8'd0,  8'd0,  8'd0);
    vecs[4] = mk(1'b0, 8'd40, 3'd3, 8'd16, 8'd32, 8'd40, 8'd0,  8'd0);
    vecs[5] = mk(1'b1, 8'd200, 3'd2, 8'd100, 8'd200, 8'd0, 8'd0, 8'd0);
    vecs[6] = mk(1'b1, 8'd255, 3'd1, 8'd255, 8'd0,  8'd0,  8'd0,  8'd0);
    vecs[7] = mk(1'b1, 8'd255, 3'd0, 8'd255, 8'd0,  8'd0,  8'd0,  8'd0);
    vecs[8] = mk(1'b1, 8'd200, 3'd1, 8'd200, 8'd0,  8'd0,  8'd0,  8'd0);
    vecs[9] = mk(1'b1, 8'd0,  3'd2, 8'd100, 8'd0,  8'd0,  8'd0,  8'd0);
    nvec = 10;

    // Reset state and first period tick.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_duty", 32'(duty_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_ready", 32'(tgt_ready_a), 32'd1);
    chk("rst_tick", 32'(tick_a), 32'd0);
    chk("rst_duty_b", 32'(duty_b), 32'd0);
    rst   = 1'b0;
    first = 0;
    for (int i = 1; i <= 20 && first == 0; i++) begin
      @(negedge clk);
      if (tick_a) first = i;
    end
    chk("first_tick_cycle", 32'(first), 32'd9);

    for (int i = 0; i < 5; i++) apply_vec(vecs[i]);

    // Request held during a ramp is only taken in the done cycle.
    sel = 1'b0;
    @(negedge clk);
    tgt_duty = 8'd72; tgt_valid_a = 1'b1;
    @(posedge clk);
    #1 tgt_duty = 8'd88;
    wait_change(8'd40, 15, ticks, cycles, changed, bad);
    chk("stall_step1", 32'(duty_s), 32'd56);
    chk("stall_flags", 32'(bad), 32'd0);
    wait_change(8'd56, 15, ticks, cycles, changed, bad);
    chk("stall_step2", 32'(duty_s), 32'd72);
    chk("stall_done", 32'(done_s), 32'd1);
    chk("stall_ready", 32'(tgt_ready_s), 32'd1);
    @(posedge clk);
    #1 tgt_valid_a = 1'b0;
    @(negedge clk);
    chk("stall_accept_busy", 32'(busy_s), 32'd1);
    chk("stall_hold_duty", 32'(duty_s), 32'd72);
    wait_change(8'd72, 15, ticks, cycles, changed, bad);
    chk("stall_step3", 32'(duty_s), 32'd88);
    chk("stall_done2", 32'(done_s), 32'd1);

    // Reset in the middle of a ramp.
    @(negedge clk);
    tgt_duty = 8'd0; tgt_valid_a = 1'b1;
    @(posedge clk);
    #1 tgt_valid_a = 1'b0;
    wait_change(8'd88, 15, ticks, cycles, changed, bad);
    chk("rmid_step1", 32'(duty_s), 32'd72);
    wait_change(8'd72, 15, ticks, cycles, changed, bad);
    chk("rmid_step2", 32'(duty_s), 32'd56);
    rst = 1'b1;
    @(negedge clk);
    chk("rmid_duty", 32'(duty_s), 32'd0);
    chk("rmid_busy", 32'(busy_s), 32'd0);
    chk("rmid_done", 32'(done_s), 32'd0);
    chk("rmid_ready", 32'(tgt_ready_s), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("rmid_no_done", 32'(done_s), 32'd0);
    chk("rmid_duty_hold", 32'(duty_s), 32'd0);

    for (int i = 5; i < nvec; i++) apply_vec(vecs[i]);

`ifdef PWM_RAMP_FAULT_EN
    sel = 1'b0;
    @(negedge clk);
    tgt_duty = 8'd64; tgt_valid_a = 1'b1;
    @(posedge clk);
    #1 tgt_valid_a = 1'b0;
    wait_change(8'd0, 15, ticks, cycles, changed, bad);
    chk("flt_step", 32'(duty_s), 32'd16);
    fault = 1'b1;
    @(negedge clk);
    chk("flt_duty", 32'(duty_s), 32'd0);
    chk("flt_ready", 32'(tgt_ready_s), 32'd0);
    chk("flt_busy", 32'(busy_s), 32'd0);
    chk("flt_done", 32'(done_s), 32'd0);
    fault_clr = 1'b1;
    @(negedge clk);
    chk("flt_clr_blocked", 32'(tgt_ready_s), 32'd0);
    fault = 1'b0; fault_clr = 1'b0; tgt_valid_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("flt_latched_ready", 32'(tgt_ready_s), 32'd0);
    chk("flt_latched_busy", 32'(busy_s), 32'd0);
    chk("flt_latched_duty", 32'(duty_s), 32'd0);
    tgt_valid_a = 1'b0; fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("flt_cleared_ready", 32'(tgt_ready_s), 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
